// File: rtl/spi_sample_fifo.sv
// spi_sample_fifo: circular-buffer, first-word-fall-through FIFO that buffers
// accelerometer sample words between the SPI receive path and the consumer.
// Optional macro SPI_FIFO_OVERWRITE_EN: a write while full (no read) replaces
// the oldest entry instead of being dropped, so the newest samples are kept.
module spi_sample_fifo #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,   // power of two, >= 2
  parameter int AF_LEVEL = 6,   // 1..DEPTH
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  input  logic              flush,
  input  logic              clr_err,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LVL    = (ADDR_W + 1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              almost_full_q, almost_full_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic wr_accept;   // word is stored this cycle
  logic rd_advance;  // oldest word leaves this cycle (pop or overwrite)
  logic ovf_set;
  logic unf_set;

  // Next-state pointer, level and flag computation; flags follow next level
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    wr_accept  = 1'b0;
    rd_advance = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;

    if (flush) begin
      // Flush wins over any request in the same cycle and raises no errors
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      ovf_set = wr_en & full_q & ~rd_en;
      unf_set = rd_en & empty_q;
`ifdef SPI_FIFO_OVERWRITE_EN
      wr_accept  = wr_en;
      rd_advance = (rd_en & ~empty_q) | ovf_set;
`else
      wr_accept  = wr_en & (~full_q | rd_en);
      rd_advance = rd_en & ~empty_q;
`endif
      if (wr_accept)  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_advance) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (wr_accept && !rd_advance)      level_d = level_q + 1'b1;
      else if (rd_advance && !wr_accept) level_d = level_q - 1'b1;
    end

    empty_d       = (level_d == '0);
    full_d        = (level_d == DEPTH_LVL);
    almost_full_d = (level_d >= AF_LVL);
    // A fresh error in the same cycle as clr_err keeps the flag set
    overflow_d    = (overflow_q  & ~clr_err) | ovf_set;
    underflow_d   = (underflow_q & ~clr_err) | unf_set;
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  // Storage array write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

  // FWFT read port: oldest word, forced to zero while empty
  always_comb begin
    rd_data = empty_q ? '0 : mem_q[rd_ptr_q];
  end

  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_spi_sample_fifo.sv
// Testbench for spi_sample_fifo: vector table, hand-written corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_spi_sample_fifo;

  localparam int DATA_W   = 16;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;
  localparam int ADDR_W   = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              flush = 1'b0;
  logic              clr_err = 1'b0;
  logic              empty, full, almost_full, overflow, underflow;
  logic [ADDR_W:0]   level;

  spi_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .flush(flush), .clr_err(clr_err), .empty(empty),
    .full(full), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a queue of stored words plus two sticky flags
  logic [DATA_W-1:0] mq[$];
  bit m_ovf = 0;
  bit m_unf = 0;

  typedef struct {
    logic              wr;
    logic [DATA_W-1:0] wd;
    logic              rd;
    logic              fl;
    logic              ce;
    int                lvl;
    logic [DATA_W-1:0] data;
    logic              emp;
    logic              unf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit wr, input logic [DATA_W-1:0] wd,
                            input bit rd, input bit fl, input bit ce);
    bit os = 0;
    bit us = 0;
    int sz = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      us = rd && (sz == 0);
      os = wr && (sz == DEPTH) && !rd;
      if (os) begin
`ifdef SPI_FIFO_OVERWRITE_EN
        void'(mq.pop_front());
        mq.push_back(wd);
`endif
      end else begin
        if (rd && sz > 0) void'(mq.pop_front());
        if (wr) mq.push_back(wd);
      end
    end
    m_ovf = (m_ovf && !ce) || os;
    m_unf = (m_unf && !ce) || us;
  endtask

  task automatic check_model(input string tag);
    int sz = mq.size();
    chk({tag, ".level"}, int'(level), sz);
    chk({tag, ".empty"}, int'(empty), int'(sz == 0));
    chk({tag, ".full"}, int'(full), int'(sz == DEPTH));
    chk({tag, ".almost_full"}, int'(almost_full), int'(sz >= AF_LEVEL));
    chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
    chk({tag, ".underflow"}, int'(underflow), int'(m_unf));
    chk({tag, ".rd_data"}, int'(rd_data), (sz > 0) ? int'(mq[0]) : 0);
  endtask

  // One clock cycle: drive at negedge, model on posedge, compare at next negedge
  task automatic cycle(input string tag, input bit wr, input logic [DATA_W-1:0] wd,
                       input bit rd, input bit fl, input bit ce);
    wr_en = wr; wr_data = wd; rd_en = rd; flush = fl; clr_err = ce;
    @(posedge clk);
    model_step(wr, wd, rd, fl, ce);
    @(negedge clk);
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
    check_model(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    vecs[0]  = '{1, 16'h1111, 0, 0, 0, 1, 16'h1111, 0, 0};
    vecs[1]  = '{1, 16'h2222, 0, 0, 0, 2, 16'h1111, 0, 0};
    vecs[2]  = '{1, 16'h3333, 0, 0, 0, 3, 16'h1111, 0, 0};
    vecs[3]  = '{0, 16'h0000, 1, 0, 0, 2, 16'h2222, 0, 0};
    vecs[4]  = '{0, 16'h0000, 1, 0, 0, 1, 16'h3333, 0, 0};
    vecs[5]  = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 0};
    vecs[6]  = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 1};
    vecs[7]  = '{0, 16'h0000, 0, 0, 1, 0, 16'h0000, 1, 0};
    vecs[8]  = '{1, 16'h4444, 1, 0, 0, 1, 16'h4444, 0, 1};
    vecs[9]  = '{0, 16'h0000, 0, 1, 1, 0, 16'h0000, 1, 0};
    vecs[10] = '{1, 16'h5555, 1, 1, 0, 0, 16'h0000, 1, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset.level", int'(level), 0);
    chk("reset.empty", int'(empty), 1);
    chk("reset.full", int'(full), 0);
    chk("reset.almost_full", int'(almost_full), 0);
    chk("reset.overflow", int'(overflow), 0);
    chk("reset.underflow", int'(underflow), 0);
    chk("reset.rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table: basic write/pop order, underflow, clear, flush
    for (int i = 0; i < 11; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].wr, vecs[i].wd, vecs[i].rd,
            vecs[i].fl, vecs[i].ce);
      chk($sformatf("vec%0d.level", i), int'(level), vecs[i].lvl);
      chk($sformatf("vec%0d.rd_data", i), int'(rd_data), int'(vecs[i].data));
      chk($sformatf("vec%0d.empty", i), int'(empty), int'(vecs[i].emp));
      chk($sformatf("vec%0d.underflow", i), int'(underflow), int'(vecs[i].unf));
      $display("vec%0d: wr=%0b rd=%0b fl=%0b level=%0d rd_data=%h", i,
               vecs[i].wr, vecs[i].rd, vecs[i].fl, level, rd_data);
    end

    // Fill to full, watermark and overflow
    for (int i = 0; i < DEPTH; i++) begin
      cycle("fill", 1, 16'hA000 + 16'(i), 0, 0, 0);
      chk($sformatf("fill%0d.almost_full", i), int'(almost_full), int'(i >= AF_LEVEL - 1));
      chk($sformatf("fill%0d.full", i), int'(full), int'(i == DEPTH - 1));
      $display("fill%0d: level=%0d af=%0b full=%0b", i, level, almost_full, full);
    end
    cycle("ovf", 1, 16'hBEEF, 0, 0, 0);
    chk("ovf.overflow", int'(overflow), 1);
    chk("ovf.level", int'(level), DEPTH);
`ifdef SPI_FIFO_OVERWRITE_EN
    chk("ovf.rd_data", int'(rd_data), 16'hA001);
`else
    chk("ovf.rd_data", int'(rd_data), 16'hA000);
`endif
    $display("ovf: overflow=%0b rd_data=%h", overflow, rd_data);
    cycle("clr", 0, 0, 0, 0, 1);
    chk("clr.overflow", int'(overflow), 0);

    // Simultaneous read+write while full, then drain
    cycle("fullrw", 1, 16'hC0DE, 1, 0, 0);
    chk("fullrw.level", int'(level), DEPTH);
    chk("fullrw.overflow", int'(overflow), 0);
    $display("fullrw: level=%0d overflow=%0b", level, overflow);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("drain.last", int'(rd_data), 16'hC0DE);
      cycle("drain", 0, 0, 1, 0, 0);
    end
    chk("drain.empty", int'(empty), 1);
    chk("drain.overflow", int'(overflow), 0);

    // Steady streaming at level 3 across several pointer wraps
    for (int i = 0; i < 3; i++) cycle("pre3", 1, DATA_W'($urandom), 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      d = DATA_W'($urandom);
      cycle("stream", 1, d, 1, 0, 0);
      chk("stream.level", int'(level), 3);
    end
    $display("stream: 20 words at level=%0d", level);

    // Flush at level 5, with requests in the same cycle ignored
    cycle("pre5", 1, 16'h0001, 0, 0, 0);
    cycle("pre5", 1, 16'h0002, 0, 0, 0);
    chk("pre5.level", int'(level), 5);
    cycle("flush", 1, 16'h0003, 1, 1, 0);
    chk("flush.level", int'(level), 0);
    chk("flush.empty", int'(empty), 1);
    chk("flush.underflow", int'(underflow), 0);
    $display("flush: level=%0d empty=%0b", level, empty);

    // Asynchronous reset mid-write at level 4
    for (int i = 0; i < 4; i++) cycle("pre4", 1, 16'h7000 + 16'(i), 0, 0, 0);
    chk("pre4.level", int'(level), 4);
    wr_en = 1; wr_data = 16'hDEAD;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.level", int'(level), 0);
    chk("arst.empty", int'(empty), 1);
    chk("arst.rd_data", int'(rd_data), 0);
    $display("arst: level=%0d empty=%0b rd_data=%h", level, empty, rd_data);
    mq.delete(); m_ovf = 0; m_unf = 0;
    @(negedge clk);
    wr_en = 0;
    rst_n = 1'b1;
    check_model("arst_post");

    // Randomized traffic: fill-biased phase then drain-biased phase
    for (int i = 0; i < 600; i++) begin
      int wp = (i < 300) ? 70 : 35;
      bit w  = ($urandom_range(0, 99) < wp);
      bit r  = ($urandom_range(0, 99) < 100 - wp);
      bit f  = ($urandom_range(0, 99) < 2);
      bit c  = ($urandom_range(0, 99) < 5);
      cycle($sformatf("rnd%0d", i), w, DATA_W'($urandom), r, f, c);
    end
    $display("random: 600 cycles, final level=%0d", level);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
